// File: rtl/nf10_wrr_input_arbiter.sv
// rtl/nf10_wrr_input_arbiter.sv - packet-granular weighted round-robin merge of NUM_QUEUES AXI4-Stream queues
module nf10_wrr_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 8,
    parameter int WEIGHT_WIDTH         = 4,
    parameter int CNTR_WIDTH           = 32
) (
    input  logic                                          axi_aclk,
    input  logic                                          axi_resetn,
    input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [NUM_QUEUES*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [NUM_QUEUES-1:0]                         s_axis_tvalid,
    output logic [NUM_QUEUES-1:0]                         s_axis_tready,
    input  logic [NUM_QUEUES-1:0]                         s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          m_axis_tlast,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0]            weights,
    input  logic                                          rst_cntrs,
    output logic                                          pkt_fwd,
    output logic [$clog2(NUM_QUEUES)-1:0]                 pkt_fwd_port,
    output logic [NUM_QUEUES*CNTR_WIDTH-1:0]              pkt_fwd_cntr
);

    localparam int QW = $clog2(NUM_QUEUES);
    localparam int SW = C_S_AXIS_DATA_WIDTH / 8;

    typedef enum logic {ST_ARB, ST_PKT} state_t;

    state_t                  state_q, state_d;
    logic [QW-1:0]           cur_q, cur_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic [CNTR_WIDTH-1:0]   cntr_q [NUM_QUEUES];
    logic [CNTR_WIDTH-1:0]   cntr_d [NUM_QUEUES];

    logic [C_S_AXIS_DATA_WIDTH-1:0]  data_a   [NUM_QUEUES];
    logic [SW-1:0]                   strb_a   [NUM_QUEUES];
    logic [C_S_AXIS_TUSER_WIDTH-1:0] user_a   [NUM_QUEUES];
    logic [WEIGHT_WIDTH-1:0]         weight_a [NUM_QUEUES];

    logic          found;
    logic [QW-1:0] pick;
    int            idx;

    genvar g;
    for (g = 0; g < NUM_QUEUES; g++) begin : g_unpack
        assign data_a[g]   = s_axis_tdata[g*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
        assign strb_a[g]   = s_axis_tstrb[g*SW +: SW];
        assign user_a[g]   = s_axis_tuser[g*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
        assign weight_a[g] = weights[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign pkt_fwd_cntr[g*CNTR_WIDTH +: CNTR_WIDTH] = cntr_q[g];
    end

    // Payload is a pure mux of the selected queue; validity is gated by the FSM below.
    assign m_axis_tdata = data_a[cur_q];
    assign m_axis_tstrb = strb_a[cur_q];
    assign m_axis_tuser = user_a[cur_q];
    assign m_axis_tlast = s_axis_tlast[cur_q];
    assign pkt_fwd_port = pkt_fwd ? cur_q : '0;

    // Arbitration decision, grant steering and credit accounting.
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        credit_d      = credit_q;
        found         = 1'b0;
        pick          = '0;
        idx           = 0;
        pkt_fwd       = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        case (state_q)
            ST_ARB: begin
                if (s_axis_tvalid[cur_q] && credit_q != '0) begin
                    state_d = ST_PKT;
                end else begin
                    // Search starts just after the current queue and ends on it.
                    for (int k = 1; k <= NUM_QUEUES; k++) begin
                        idx = int'(cur_q) + k;
                        if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
                        pick = QW'(idx);
                        if (!found && s_axis_tvalid[pick]) begin
                            found    = 1'b1;
                            cur_d    = pick;
                            credit_d = (weight_a[pick] == '0) ? WEIGHT_WIDTH'(1) : weight_a[pick];
                            state_d  = ST_PKT;
                        end
                    end
                end
            end
            ST_PKT: begin
                m_axis_tvalid        = s_axis_tvalid[cur_q];
                s_axis_tready[cur_q] = m_axis_tready;
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    pkt_fwd = 1'b1;
                    if (credit_q != '0) credit_d = credit_q - WEIGHT_WIDTH'(1);
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Per-queue forwarded-packet counters; clear wins over increment.
    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            cntr_d[i] = cntr_q[i];
            if (rst_cntrs) begin
                cntr_d[i] = '0;
            end else if (pkt_fwd && cur_q == QW'(i)) begin
                cntr_d[i] = cntr_q[i] + CNTR_WIDTH'(1);
            end
        end
    end

    // State registers; reset parks the pointer on the last queue so queue 0 is searched first.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q  <= ST_ARB;
            cur_q    <= QW'(NUM_QUEUES - 1);
            credit_q <= '0;
            for (int i = 0; i < NUM_QUEUES; i++) cntr_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
            for (int i = 0; i < NUM_QUEUES; i++) cntr_q[i] <= cntr_d[i];
        end
    end

endmodule

// File: tb/tb_nf10_wrr_input_arbiter.sv
// tb/tb_nf10_wrr_input_arbiter.sv - randomized self-checking bench for nf10_wrr_input_arbiter
module tb_nf10_wrr_input_arbiter;

    localparam int NQ = 8;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;
    localparam int WW = 4;
    localparam int CW = 32;
    localparam int QW = $clog2(NQ);

    logic                axi_aclk;
    logic                axi_resetn;
    logic [NQ*DW-1:0]    s_axis_tdata;
    logic [NQ*SW-1:0]    s_axis_tstrb;
    logic [NQ*UW-1:0]    s_axis_tuser;
    logic [NQ-1:0]       s_axis_tvalid;
    logic [NQ-1:0]       s_axis_tready;
    logic [NQ-1:0]       s_axis_tlast;
    logic [DW-1:0]       m_axis_tdata;
    logic [SW-1:0]       m_axis_tstrb;
    logic [UW-1:0]       m_axis_tuser;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;
    logic [NQ*WW-1:0]    weights;
    logic                rst_cntrs;
    logic                pkt_fwd;
    logic [QW-1:0]       pkt_fwd_port;
    logic [NQ*CW-1:0]    pkt_fwd_cntr;

    nf10_wrr_input_arbiter #(
        .C_M_AXIS_DATA_WIDTH (DW), .C_S_AXIS_DATA_WIDTH (DW),
        .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
        .NUM_QUEUES(NQ), .WEIGHT_WIDTH(WW), .CNTR_WIDTH(CW)
    ) dut (
        .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .weights(weights), .rst_cntrs(rst_cntrs),
        .pkt_fwd(pkt_fwd), .pkt_fwd_port(pkt_fwd_port), .pkt_fwd_cntr(pkt_fwd_cntr)
    );

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    // Bench state: source beat lists, expected beat lists, model pointer/credit, scoreboard.
    logic [32:0] srcq [NQ][$];
    logic [32:0] expq [NQ][$];
    int pend [NQ];
    int wts [NQ];
    int exp_cntr [NQ];
    int order [$];
    int got [$];
    int m_ptr, m_credit;
    int n_checks, n_pass;

    function automatic logic [CW-1:0] cntr_of(input int q);
        return pkt_fwd_cntr[q*CW +: CW];
    endfunction

    task automatic clear_inputs();
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
    endtask

    task automatic do_reset();
        axi_resetn    = 1'b0;
        clear_inputs();
        rst_cntrs     = 1'b0;
        m_axis_tready = 1'b0;
        for (int q = 0; q < NQ; q++) begin
            srcq[q].delete();
            expq[q].delete();
            pend[q]     = 0;
            exp_cntr[q] = 0;
            wts[q]      = 1;
        end
        m_ptr    = NQ - 1;
        m_credit = 0;
        repeat (2) @(posedge axi_aclk);
        #1 axi_resetn = 1'b1;
    endtask

    task automatic apply_weights();
        for (int q = 0; q < NQ; q++) weights[q*WW +: WW] = 4'(wts[q]);
    endtask

    task automatic add_pkt(input int q, input int len);
        logic [32:0] b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), 4'(q), 28'($urandom)};
            srcq[q].push_back(b);
            expq[q].push_back(b);
        end
        pend[q]++;
    endtask

    task automatic drive_inputs();
        logic [32:0] b;
        for (int q = 0; q < NQ; q++) begin
            if (srcq[q].size() > 0) begin
                b = srcq[q][0];
                s_axis_tvalid[q] = 1'b1;
                s_axis_tlast[q]  = b[32];
                s_axis_tdata[q*DW +: DW] = {{(DW-32){1'b0}}, b[31:0]};
                s_axis_tuser[q*UW +: UW] = {{(UW-32){1'b0}}, ~b[31:0]};
                s_axis_tstrb[q*SW +: SW] = b[31:0] ^ 32'h5a5a5a5a;
            end else begin
                s_axis_tvalid[q] = 1'b0;
                s_axis_tlast[q]  = 1'b0;
                s_axis_tdata[q*DW +: DW] = '0;
                s_axis_tuser[q*UW +: UW] = '0;
                s_axis_tstrb[q*SW +: SW] = '0;
            end
        end
    endtask

    // Reference: every pending queue is backlogged, so a turn is min(credit, packets left)
    // and the pointer moves to the next non-empty queue after the current one.
    task automatic build_order();
        int rem [NQ];
        int total, gq, i;
        total = 0;
        for (int q = 0; q < NQ; q++) begin
            rem[q] = pend[q];
            total += pend[q];
            pend[q] = 0;
        end
        order.delete();
        while (total > 0) begin
            if (rem[m_ptr] > 0 && m_credit > 0) begin
                gq = m_ptr;
            end else begin
                gq = -1;
                for (int k = 1; k <= NQ; k++) begin
                    i = (m_ptr + k) % NQ;
                    if (gq < 0 && rem[i] > 0) gq = i;
                end
                m_ptr    = gq;
                m_credit = (wts[gq] == 0) ? 1 : wts[gq];
            end
            order.push_back(gq);
            rem[gq]--;
            m_credit--;
            total--;
        end
    endtask

    // Streams all pending packets; bp_mode 0 = always ready, 1 = random, 2 = 5-cycle stall after 2nd beat.
    task automatic run_traffic(input int bp_mode);
        int e, since_last, cyc, beats, stall_left;
        logic [32:0] hb;
        logic hs;
        logic [NQ-1:0] pop_mask, exp_rdy;
        build_order();
        got.delete();
        since_last = 0;
        cyc        = 0;
        beats      = 0;
        stall_left = 0;
        hb         = '0;
        drive_inputs();
        m_axis_tready = (bp_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (order.size() > 0 && cyc < 3000) begin
            @(negedge axi_aclk);
            cyc++;
            e = order[0];
            if (since_last == 0) begin
                n_checks++;
                if (m_axis_tvalid !== 1'b0) $display("FAIL bubble_valid: got %b expected 0", m_axis_tvalid);
                else n_pass++;
                n_checks++;
                if (s_axis_tready !== '0) $display("FAIL bubble_tready: got %b expected 0", s_axis_tready);
                else n_pass++;
            end else if (since_last == 1) begin
                n_checks++;
                if (m_axis_tvalid !== 1'b1) $display("FAIL grant_start: got %b expected 1", m_axis_tvalid);
                else n_pass++;
            end
            if (m_axis_tvalid === 1'b1 && expq[e].size() > 0) begin
                hb = expq[e][0];
                exp_rdy = m_axis_tready ? (NQ'(1) << e) : '0;
                n_checks++;
                if (m_axis_tdata[31:0] !== hb[31:0] || m_axis_tlast !== hb[32])
                    $display("FAIL beat q%0d: got %h/%b expected %h/%b", e, m_axis_tdata[31:0], m_axis_tlast, hb[31:0], hb[32]);
                else n_pass++;
                n_checks++;
                if (m_axis_tuser[31:0] !== ~hb[31:0] || m_axis_tstrb !== (hb[31:0] ^ 32'h5a5a5a5a))
                    $display("FAIL sideband q%0d: got %h/%h expected %h/%h", e, m_axis_tuser[31:0], m_axis_tstrb, ~hb[31:0], hb[31:0] ^ 32'h5a5a5a5a);
                else n_pass++;
                n_checks++;
                if (s_axis_tready !== exp_rdy) $display("FAIL s_tready: got %b expected %b", s_axis_tready, exp_rdy);
                else n_pass++;
            end
            hs = m_axis_tvalid && m_axis_tready;
            n_checks++;
            if (pkt_fwd !== (hs && hb[32])) $display("FAIL pkt_fwd: got %b expected %b", pkt_fwd, hs && hb[32]);
            else n_pass++;
            if (hs && hb[32]) begin
                n_checks++;
                if (pkt_fwd_port !== QW'(e)) $display("FAIL pkt_fwd_port: got %0d expected %0d", pkt_fwd_port, e);
                else n_pass++;
            end
            pop_mask = s_axis_tvalid & s_axis_tready;
            if (hs && expq[e].size() > 0) begin
                void'(expq[e].pop_front());
                beats++;
                if (bp_mode == 2 && beats == 2) stall_left = 5;
                if (hb[32]) begin
                    order.pop_front();
                    got.push_back(int'(pkt_fwd_port));
                    exp_cntr[e]++;
                    since_last = 0;
                end else begin
                    since_last = 2;
                end
            end else if (since_last < 2) begin
                since_last++;
            end
            @(posedge axi_aclk);
            #1;
            for (int q = 0; q < NQ; q++) if (pop_mask[q] && srcq[q].size() > 0) void'(srcq[q].pop_front());
            drive_inputs();
            if (bp_mode == 1) m_axis_tready = ($urandom_range(0, 3) != 0);
            else if (stall_left > 0) begin
                m_axis_tready = 1'b0;
                stall_left--;
            end else m_axis_tready = 1'b1;
        end
        n_checks++;
        if (order.size() != 0) $display("FAIL timeout: %0d packets still expected", order.size());
        else n_pass++;
        @(negedge axi_aclk);
        for (int q = 0; q < NQ; q++) begin
            n_checks++;
            if (cntr_of(q) !== CW'(exp_cntr[q])) $display("FAIL cntr q%0d: got %0d expected %0d", q, cntr_of(q), exp_cntr[q]);
            else n_pass++;
        end
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        apply_weights();
        m_axis_tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge axi_aclk);
            n_checks++;
            if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || pkt_fwd !== 1'b0 || pkt_fwd_port !== '0)
                $display("FAIL reset_idle: got v=%b r=%b f=%b p=%0d expected all 0", m_axis_tvalid, s_axis_tready, pkt_fwd, pkt_fwd_port);
            else n_pass++;
        end
        n_checks++;
        if (pkt_fwd_cntr !== '0) $display("FAIL reset_cntrs: got %h expected 0", pkt_fwd_cntr);
        else n_pass++;
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic test_equal_rr();
        int exp_o [6] = '{0, 3, 7, 0, 3, 7};
        do_reset();
        apply_weights();
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 3);
            add_pkt(3, 3);
            add_pkt(7, 3);
        end
        run_traffic(0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got.size() <= i || got[i] !== exp_o[i]) $display("FAIL rr_order[%0d]: got %0d expected %0d", i, (got.size() > i) ? got[i] : -1, exp_o[i]);
            else n_pass++;
        end
        n_checks++;
        if (cntr_of(0) !== 2 || cntr_of(3) !== 2 || cntr_of(7) !== 2)
            $display("FAIL rr_cntrs: got %0d/%0d/%0d expected 2/2/2", cntr_of(0), cntr_of(3), cntr_of(7));
        else n_pass++;
    endtask

    task automatic test_weighted();
        int exp_o [8] = '{1, 1, 1, 2, 1, 1, 1, 2};
        do_reset();
        wts[1] = 3;
        wts[2] = 1;
        apply_weights();
        for (int i = 0; i < 6; i++) add_pkt(1, 1);
        for (int i = 0; i < 2; i++) add_pkt(2, 1);
        run_traffic(0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got.size() <= i || got[i] !== exp_o[i]) $display("FAIL wrr_order[%0d]: got %0d expected %0d", i, (got.size() > i) ? got[i] : -1, exp_o[i]);
            else n_pass++;
        end
        n_checks++;
        if (cntr_of(1) !== 6 || cntr_of(2) !== 2) $display("FAIL wrr_cntrs: got %0d/%0d expected 6/2", cntr_of(1), cntr_of(2));
        else n_pass++;
    endtask

    task automatic test_weight_zero();
        int exp_o [6] = '{4, 5, 4, 5, 4, 5};
        do_reset();
        wts[4] = 0;
        wts[5] = 1;
        apply_weights();
        for (int i = 0; i < 3; i++) begin
            add_pkt(4, 2);
            add_pkt(5, 2);
        end
        run_traffic(1);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got.size() <= i || got[i] !== exp_o[i]) $display("FAIL w0_order[%0d]: got %0d expected %0d", i, (got.size() > i) ? got[i] : -1, exp_o[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        apply_weights();
        add_pkt(0, 4);
        add_pkt(6, 2);
        run_traffic(2);
        n_checks++;
        if (got.size() != 2 || got[0] !== 0 || got[1] !== 6) $display("FAIL bp_order: got %0d packets expected q0 then q6", got.size());
        else n_pass++;
    endtask

    task automatic test_random();
        int total;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            total = 0;
            for (int q = 0; q < NQ; q++) wts[q] = $urandom_range(0, 3);
            apply_weights();
            for (int q = 0; q < NQ; q++) begin
                for (int p = $urandom_range(0, 3); p > 0; p--) begin
                    add_pkt(q, $urandom_range(1, 4));
                    total++;
                end
            end
            if (total == 0) add_pkt($urandom_range(0, NQ - 1), 2);
            run_traffic($urandom_range(0, 1));
        end
    endtask

    task automatic test_cntr_clear();
        int c;
        do_reset();
        apply_weights();
        for (int i = 0; i < 9; i++) add_pkt(2, 1);
        run_traffic(0);
        n_checks++;
        if (cntr_of(2) !== 9) $display("FAIL clr_pre: got %0d expected 9", cntr_of(2));
        else n_pass++;
        s_axis_tvalid[2] = 1'b1;
        s_axis_tlast[2]  = 1'b1;
        m_axis_tready    = 1'b1;
        c = 0;
        do begin
            @(negedge axi_aclk);
            c++;
        end while (m_axis_tvalid !== 1'b1 && c < 10);
        n_checks++;
        if (pkt_fwd !== 1'b1) $display("FAIL clr_fwd: got %b expected 1", pkt_fwd);
        else n_pass++;
        rst_cntrs = 1'b1;
        @(posedge axi_aclk);
        #1;
        rst_cntrs = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        @(negedge axi_aclk);
        n_checks++;
        if (pkt_fwd_cntr !== '0) $display("FAIL clr_cntrs: got cntr2=%0d expected 0", cntr_of(2));
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int c;
        do_reset();
        apply_weights();
        s_axis_tvalid[1] = 1'b1;
        s_axis_tlast[1]  = 1'b0;
        m_axis_tready    = 1'b0;
        c = 0;
        do begin
            @(negedge axi_aclk);
            c++;
        end while (m_axis_tvalid !== 1'b1 && c < 10);
        n_checks++;
        if (m_axis_tvalid !== 1'b1) $display("FAIL ar_grant: got %b expected 1", m_axis_tvalid);
        else n_pass++;
        #2 axi_resetn = 1'b0;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0) $display("FAIL async_reset: got v=%b r=%b expected 0", m_axis_tvalid, s_axis_tready);
        else n_pass++;
        @(posedge axi_aclk);
        #1;
        clear_inputs();
        axi_resetn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        weights  = '0;
        test_reset();
        test_equal_rr();
        test_weighted();
        test_weight_zero();
        test_backpressure();
        test_random();
        test_cntr_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nf10_wrr_input_arbiter.md
Name: nf10_wrr_input_arbiter

Overview:
Packet-granular weighted round-robin arbiter. It merges NUM_QUEUES AXI4-Stream RX queues onto one master stream toward the output port lookup. It generalises the fixed 5-port round-robin arbiter with a parametrised channel count and flattened slave buses. Each queue has a runtime weight (packets per turn) and a per-queue forwarded-packet counter, so register logic can export arbitration statistics.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, master tdata width; must equal C_S_AXIS_DATA_WIDTH.
C_S_AXIS_DATA_WIDTH, 256, per-queue slave tdata width.
C_M_AXIS_TUSER_WIDTH, 128, master tuser width; must equal C_S_AXIS_TUSER_WIDTH.
C_S_AXIS_TUSER_WIDTH, 128, per-queue slave tuser width.
NUM_QUEUES, 8, number of slave queues; legal range 2..16.
WEIGHT_WIDTH, 4, bits per queue weight.
CNTR_WIDTH, 32, bits per forwarded-packet counter.

Ports:
axi_aclk  in  1  sole clock.
axi_resetn  in  1  asynchronous active-low reset.
s_axis_tdata  in  NUM_QUEUES*C_S_AXIS_DATA_WIDTH  queue i occupies slice i.
s_axis_tstrb  in  NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8  per-queue strobes.
s_axis_tuser  in  NUM_QUEUES*C_S_AXIS_TUSER_WIDTH  per-queue tuser.
s_axis_tvalid  in  NUM_QUEUES  per-queue valid.
s_axis_tready  out  NUM_QUEUES  per-queue ready.
s_axis_tlast  in  NUM_QUEUES  per-queue last.
m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  merged data.
m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  merged strobes.
m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  merged tuser.
m_axis_tvalid  out  1  merged valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  merged last.
weights  in  NUM_QUEUES*WEIGHT_WIDTH  packets per turn for each queue; 0 is treated as 1.
rst_cntrs  in  1  synchronous clear of all counters.
pkt_fwd  out  1  pulses for one cycle on each forwarded last beat.
pkt_fwd_port  out  clog2(NUM_QUEUES)  queue index of the current pulse.
pkt_fwd_cntr  out  NUM_QUEUES*CNTR_WIDTH  per-queue forwarded-packet counters.

Behaviour:
- Reset (asynchronous, active low):
  - Outputs: m_axis_tvalid=0, s_axis_tready=0, pkt_fwd=0, pkt_fwd_port=0, all counters=0.
  - Internal: state=ARB, cur=NUM_QUEUES-1, credit=0, so the first search starts at queue 0.
- FSM has two states, ARB and PKT.
- ARB (a single decision cycle):
  - If s_axis_tvalid[cur] and credit!=0: register sel=cur and go to PKT.
  - Otherwise search i=cur+1 .. cur+NUM_QUEUES (mod NUM_QUEUES) for the first queue with tvalid set. Then set cur=sel=i, load credit=max(weights[i],1), go to PKT.
  - If no queue is valid, stay in ARB; cur and credit are unchanged.
  - Weights are sampled only at credit load. Changing weights mid-turn takes effect at the next load.
- PKT:
  - m_axis_tdata/tstrb/tuser/tvalid/tlast are a combinational mux of queue sel.
  - s_axis_tready[sel]=m_axis_tready; all other tready bits are 0. In ARB, all tready bits are 0.
- Packet end: on m_axis_tvalid & m_axis_tready & m_axis_tlast:
  - decrement credit (floor 0);
  - pkt_fwd=1 and pkt_fwd_port=sel, both combinational, valid that cycle;
  - next state ARB.
- Throughput and latency:
  - Exactly one bubble cycle (the ARB cycle) between packets.
  - Data latency is 0 cycles; no buffering.
- Grant is held from the first beat to tlast regardless of other queues' tvalid. Packets are never interleaved.
- A packet accepted while credit remains lets the same queue keep the grant. A turn ends when credit reaches 0, or when the queue is not valid in ARB; the pointer then moves on and leftover credit is discarded.
- A one-beat packet (tvalid & tlast on the first beat) is legal.
- Backpressure (m_axis_tready=0) holds the selected beat. No state change.
- Counters:
  - pkt_fwd_cntr[sel] increments on pkt_fwd and wraps modulo 2^CNTR_WIDTH.
  - rst_cntrs clears all counters next edge and overrides a simultaneous increment.
- Reset asserted mid-packet returns the block immediately to reset state and abandons the packet. Upstream re-presents per its own reset.

Test Plan:
1. Reset, then hold all tvalid=0 for 20 cycles -> m_axis_tvalid=0, tready=0, counters 0.
2. NUM_QUEUES=8, weights all 1, queues 0,3,7 each hold 3-beat packets continuously -> output order 0,3,7,0,3,7; one bubble between packets; after 6 packets cntr[0]=cntr[3]=cntr[7]=2.
3. Weights q1=3, q2=1, both backlogged with 1-beat packets -> order 1,1,1,2,1,1,1,2; after 8 packets cntr[1]=6, cntr[2]=2.
4. Weight 0 on q4 with q5 backlogged -> q4 gets exactly 1 packet per turn, alternating with q5.
5. Drop m_axis_tready for 5 cycles mid-packet while another queue asserts tvalid -> grant held, data stable, no beat lost or duplicated, tready to the other queue stays 0.
6. rst_cntrs asserted in the same cycle as a pkt_fwd on q2 (cntr=9) -> cntr[2]=0 next cycle. Separately, assert axi_resetn=0 mid-packet without a clock edge -> m_axis_tvalid drops to 0 asynchronously.
